// File: rtl/vga_dither_pwm.sv
// vga_dither_pwm: ordered PWM dither of an IW-bit {R,G,B} pixel down to OW bits
// with a two-stage pixel pipeline and matching delayed sync/de outputs.
// Define VGA_DITHER_FRAME_EN to add the per-frame counter (temporal dither in mode 3).
`timescale 1ns/1ps
module vga_dither_pwm #(
    parameter int unsigned IW = 8,
    parameter int unsigned OW = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [1:0]        mode,
    input  logic              csync_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              csync,
    input  logic              de,
    input  logic [3*IW-1:0]   din,
    output logic [3*OW-1:0]   dout,
    output logic              hs_out,
    output logic              vs_out,
    output logic              cs_out,
    output logic              de_out
);

    localparam int unsigned F = IW - OW;

    // Reject configurations with no fraction bits or a threshold wider than 4 bits
    if (IW <= OW || (IW - OW) > 4) begin : g_bad_width
        $error("vga_dither_pwm: IW-OW must be in the range 1..4");
    end

    // Counter / mode state
    logic [F-1:0] pcnt_q, pcnt_d;
    logic [F-1:0] lcnt_q, lcnt_d;
    logic [1:0]   amode_q, amode_d;
    logic         lsync_prev_q, vs_prev_q;
    logic [F-1:0] fcnt_c;

    // Stage 1: captured pixel, timing and threshold
    logic [3*IW-1:0] pix1_q;
    logic [F-1:0]    t1_q;
    logic            dith1_q, hs1_q, vs1_q, cs1_q, de1_q;

    // Stage 2: registered outputs
    logic [3*OW-1:0] dout_q;
    logic            hs2_q, vs2_q, cs2_q, de2_q;

    logic            lsync_c, lrise_c, vrise_c;
    logic [F-1:0]    t_c;
    logic [3*OW-1:0] dith_c;

    assign lsync_c = csync_en ? csync : hsync;
    assign lrise_c = lsync_c & ~lsync_prev_q;
    assign vrise_c = vsync & ~vs_prev_q;

    // Next-state for pixel/line counters and the frame-latched dither mode
    always_comb begin
        pcnt_d  = lsync_c ? '0 : pcnt_q + F'(1);
        lcnt_d  = lcnt_q;
        if (vsync) begin
            lcnt_d = '0;
        end else if (lrise_c) begin
            lcnt_d = lcnt_q + F'(1);
        end
        amode_d = vrise_c ? mode : amode_q;
    end

    // Counter and mode registers, advanced only on pixel enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q       <= '0;
            lcnt_q       <= '0;
            amode_q      <= 2'd0;
            lsync_prev_q <= 1'b0;
            vs_prev_q    <= 1'b0;
        end else if (ce_pix) begin
            pcnt_q       <= pcnt_d;
            lcnt_q       <= lcnt_d;
            amode_q      <= amode_d;
            lsync_prev_q <= lsync_c;
            vs_prev_q    <= vsync;
        end
    end

`ifdef VGA_DITHER_FRAME_EN
    logic [F-1:0] fcnt_q, fcnt_d;

    assign fcnt_d = vrise_c ? fcnt_q + F'(1) : fcnt_q;
    assign fcnt_c = fcnt_q;

    // Frame counter, stepped on each vsync rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt_q <= '0;
        end else if (ce_pix) begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    assign fcnt_c = '0;
`endif

    // Ordered-dither threshold selected by the active mode (sums wrap modulo 2^F)
    always_comb begin
        t_c = '0;
        case (amode_q)
            2'd1:    t_c = pcnt_q;
            2'd2:    t_c = pcnt_q + lcnt_q;
            2'd3:    t_c = pcnt_q + lcnt_q + fcnt_c;
            default: t_c = '0;
        endcase
    end

    // Stage 1 capture; blanked pixels are zeroed here so stage 2 emits zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix1_q  <= '0;
            t1_q    <= '0;
            dith1_q <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            cs1_q   <= 1'b0;
            de1_q   <= 1'b0;
        end else if (ce_pix) begin
            pix1_q  <= de ? din : '0;
            t1_q    <= t_c;
            dith1_q <= (amode_q != 2'd0);
            hs1_q   <= hsync;
            vs1_q   <= vsync;
            cs1_q   <= csync;
            de1_q   <= de;
        end
    end

    // Per-channel truncate-and-round-up with saturation at full scale
    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [IW-1:0] v_c;
        logic [OW-1:0] hi_c;
        logic [F-1:0]  lo_c;
        logic          inc_c;

        assign v_c   = pix1_q[g*IW +: IW];
        assign hi_c  = v_c[IW-1:F];
        assign lo_c  = v_c[F-1:0];
        assign inc_c = dith1_q && (t1_q < lo_c) && (hi_c != {OW{1'b1}});
        assign dith_c[g*OW +: OW] = hi_c + OW'(inc_c);
    end

    // Stage 2 output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            cs2_q  <= 1'b0;
            de2_q  <= 1'b0;
        end else if (ce_pix) begin
            dout_q <= dith_c;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            cs2_q  <= cs1_q;
            de2_q  <= de1_q;
        end
    end

    assign dout   = dout_q;
    assign hs_out = hs2_q;
    assign vs_out = vs2_q;
    assign cs_out = cs2_q;
    assign de_out = de2_q;

endmodule

// File: tb/tb_vga_dither_pwm.sv
// Directed testbench for vga_dither_pwm (IW=8, OW=6).
`timescale 1ns/1ps
module tb_vga_dither_pwm;

    localparam int unsigned IW = 8;
    localparam int unsigned OW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              ce_pix;
    logic [1:0]        mode;
    logic              csync_en;
    logic              hsync, vsync, csync, de;
    logic [3*IW-1:0]   din;
    logic [3*OW-1:0]   dout;
    logic              hs_out, vs_out, cs_out, de_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_dither_pwm #(.IW(IW), .OW(OW)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .mode     (mode),
        .csync_en (csync_en),
        .hsync    (hsync),
        .vsync    (vsync),
        .csync    (csync),
        .de       (de),
        .din      (din),
        .dout     (dout),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .cs_out   (cs_out),
        .de_out   (de_out)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [17:0] rx(input logic [5:0] r);
        return {r, 12'h000};
    endfunction

    // One pixel-enabled clock; outputs are looked at 1ns after the edge
    task automatic cyc(input logic [23:0] d, input logic h, input logic v, input logic e);
        din = d; hsync = h; vsync = v; de = e;
        @(posedge clk); #1;
    endtask

    // Vertical sync: hsync rises while vsync is high so the next line starts at lcnt=0
    task automatic frame();
        csync = 1'b0;
        cyc(24'h0, 1'b0, 1'b1, 1'b0);
        cyc(24'h0, 1'b1, 1'b1, 1'b0);
    endtask

    // Sync pulse (with blanked data) then 4 active pixels; output lags input by one call
    task automatic line4(input string tag, input logic [23:0] d,
                         input logic [17:0] e0, input logic [17:0] e1,
                         input logic [17:0] e2, input logic [17:0] e3,
                         input logic use_cs);
        csync_en = use_cs;
        csync    = use_cs;
        cyc(d, 1'b1, 1'b0, 1'b0);
        csync    = 1'b0;
        cyc(d, use_cs, 1'b0, 1'b1);
        chk({tag, ".blank"}, 0, 32'(dout), 32'h0);
        chk({tag, ".hs"},    0, 32'(hs_out), 32'h1);
        chk({tag, ".cs"},    0, 32'(cs_out), 32'(use_cs));
        chk({tag, ".de"},    0, 32'(de_out), 32'h0);
        cyc(d, use_cs, 1'b0, 1'b1);
        chk(tag, 0, 32'(dout), 32'(e0));
        chk({tag, ".de"}, 1, 32'(de_out), 32'h1);
        cyc(d, use_cs, 1'b0, 1'b1);
        chk(tag, 1, 32'(dout), 32'(e1));
        cyc(d, use_cs, 1'b0, 1'b1);
        chk(tag, 2, 32'(dout), 32'(e2));
        cyc(d, use_cs, 1'b0, 1'b0);
        chk(tag, 3, 32'(dout), 32'(e3));
        csync_en = 1'b0;
        hsync    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] fexp [4][4];

        // Reset with every input active: all outputs must stay low
        reset = 1'b1; ce_pix = 1'b1; mode = 2'd3; csync_en = 1'b0;
        hsync = 1'b1; vsync = 1'b1; csync = 1'b1; de = 1'b1; din = 24'hFFFFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.dout", 0, 32'(dout), 32'h0);
        chk("rst.hs",   0, 32'(hs_out), 32'h0);
        chk("rst.vs",   0, 32'(vs_out), 32'h0);
        chk("rst.cs",   0, 32'(cs_out), 32'h0);
        chk("rst.de",   0, 32'(de_out), 32'h0);
        hsync = 1'b0; vsync = 1'b0; csync = 1'b0; de = 1'b0; din = 24'h0;
        reset = 1'b0;

        // Mode 1 line PWM, then same pattern with csync as the line source
        mode = 2'd1;
        frame();
        line4("pwm", 24'h410000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h10), 1'b0);
        line4("csync", 24'h410000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h10), 1'b1);

        // Mode 2 requested mid-frame stays deferred; then spatial offset on lcnt 0 and 1
        mode = 2'd2;
        line4("defer12", 24'h410000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h10), 1'b0);
        frame();
        line4("m2.l0", 24'h420000, rx(6'h11), rx(6'h11), rx(6'h10), rx(6'h10), 1'b0);
        line4("m2.l1", 24'h420000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h11), 1'b0);

        // Saturation in each mode
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            frame();
            line4("sat", 24'hFFFFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0);
        end

        // Mode change 1 -> 0 takes effect only at the next vsync rise
        mode = 2'd1;
        frame();
        line4("m1", 24'h410000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h10), 1'b0);
        mode = 2'd0;
        line4("defer10", 24'h410000, rx(6'h11), rx(6'h10), rx(6'h10), rx(6'h10), 1'b0);
        frame();
        line4("m0", 24'h410000, rx(6'h10), rx(6'h10), rx(6'h10), rx(6'h10), 1'b0);

        // ce_pix low for 5 clocks mid-line with disruptive inputs: everything holds
        mode = 2'd1;
        frame();
        cyc(24'h430000, 1'b1, 1'b0, 1'b0);
        cyc(24'h430000, 1'b0, 1'b0, 1'b1);
        cyc(24'h430000, 1'b0, 1'b0, 1'b1);
        chk("gate.pre", 0, 32'(dout), 32'(rx(6'h11)));
        mode = 2'd0; ce_pix = 1'b0;
        din = 24'h00FFFF; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("gate.hold", 0, 32'(dout), 32'(rx(6'h11)));
        chk("gate.de",   0, 32'(de_out), 32'h1);
        chk("gate.hs",   0, 32'(hs_out), 32'h0);
        ce_pix = 1'b1;
        cyc(24'h430000, 1'b0, 1'b0, 1'b1);
        chk("gate", 1, 32'(dout), 32'(rx(6'h11)));
        cyc(24'h430000, 1'b0, 1'b0, 1'b1);
        chk("gate", 2, 32'(dout), 32'(rx(6'h11)));
        cyc(24'h430000, 1'b0, 1'b0, 1'b0);
        chk("gate", 3, 32'(dout), 32'(rx(6'h10)));

        // Reset mid-line clears outputs immediately; first pixel after release lags by 2
        cyc(24'hFFFFFF, 1'b1, 1'b0, 1'b1);
        cyc(24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        chk("prerst.dout", 0, 32'(dout), 32'h3FFFF);
        chk("prerst.hs",   0, 32'(hs_out), 32'h1);
        reset = 1'b1;
        #3;
        chk("midrst.dout", 0, 32'(dout), 32'h0);
        chk("midrst.hs",   0, 32'(hs_out), 32'h0);
        chk("midrst.de",   0, 32'(de_out), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(24'h410000, 1'b0, 1'b0, 1'b1);
        chk("post.dout", 1, 32'(dout), 32'h0);
        chk("post.de",   1, 32'(de_out), 32'h0);
        cyc(24'h410000, 1'b0, 1'b0, 1'b1);
        chk("post.dout", 2, 32'(dout), 32'(rx(6'h10)));
        chk("post.de",   2, 32'(de_out), 32'h1);

        // Mode 3 over 4 frames; frame counter is 1,2,3,0 after the reset above
`ifdef VGA_DITHER_FRAME_EN
        fexp[0] = '{6'h10, 6'h10, 6'h10, 6'h11};
        fexp[1] = '{6'h10, 6'h10, 6'h11, 6'h10};
        fexp[2] = '{6'h10, 6'h11, 6'h10, 6'h10};
        fexp[3] = '{6'h11, 6'h10, 6'h10, 6'h10};
`else
        for (int f = 0; f < 4; f++) fexp[f] = '{6'h11, 6'h10, 6'h10, 6'h10};
`endif
        mode = 2'd3;
        for (int f = 0; f < 4; f++) begin
            frame();
            line4("m3", 24'h410000, rx(fexp[f][0]), rx(fexp[f][1]),
                  rx(fexp[f][2]), rx(fexp[f][3]), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
